// File: rtl/mux_scan_serializer.sv
// Serializes an 8-bit word through an external 8-to-1 mux: the block drives the
// captured word and a scan index, and forwards the mux output as the serial bit.
module mux_scan_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [8-1:0]        data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [8-1:0]        a_o,
  output logic [3-1:0]        s_o,
  input  logic                y_i,
  output logic                bit_o,
  output logic                bit_valid_o,
  input  logic                bit_ready_i,
  output logic                last_o
);

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 3;
  localparam logic [SW-1:0] S_FIRST = MSB_FIRST ? SW'(7) : SW'(0);
  localparam logic [SW-1:0] S_LAST  = MSB_FIRST ? SW'(0) : SW'(7);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_live;
  logic [DW-1:0]   r_a;
  logic [SW-1:0]   r_s;
  logic            w_shift;
  logic            w_last;
  logic            w_ready;
  logic            w_accept;
  logic            w_xfer;

  // r_live keeps ready low until the first edge after reset is released
  assign w_shift  = (r_state == SHIFT);
  assign w_last   = w_shift && (r_s == S_LAST);
  assign w_ready  = r_live && (r_state == IDLE);
  assign w_accept = valid_i && w_ready;
  assign w_xfer   = w_shift && bit_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SHIFT;
      SHIFT:   if (w_xfer && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Index parks on the final position once the last bit is taken; no wrap
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a <= '0;
      r_s <= S_FIRST;
    end else if (w_accept) begin
      r_a <= data_i;
      r_s <= S_FIRST;
    end else if (w_xfer && !w_last) begin
      r_s <= MSB_FIRST ? (r_s - SW'(1)) : (r_s + SW'(1));
    end
  end

  assign ready_o     = w_ready;
  assign a_o         = r_a;
  assign s_o         = r_s;
  assign bit_valid_o = w_shift;
  assign last_o      = w_last;
  assign bit_o       = w_shift ? y_i : 1'b0;

endmodule
